xprog_arb: RTL and testbench
============================

XPROG_ARB -- requirements
Module: xprog_arb

Interface
REQ-001 SHALL have parameter: ADDR_W, `PROG_RAM_ADDR_W, program RAM word address width.
REQ-002 SHALL have parameter: DW, `DATA_W, data word width.
REQ-003 SHALL have parameter: MAX_BURST, 16, maximum DMA transfers per grant while host waits; minimum value 1.
REQ-004 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: h_req  input  1 / h_we  input  1 / h_addr  input  ADDR_W / h_wdata  input  DW  host data-bus request.
REQ-007 SHALL have ports: h_gnt  output  1 / h_rdata  output  DW / h_rvalid  output  1  host grant and read return.
REQ-008 SHALL have ports: d_req  input  1 / d_we  input  1 / d_last  input  1 / d_addr  input  ADDR_W / d_wdata  input  DW  DMA request; d_last marks the final burst beat.
REQ-009 SHALL have ports: d_gnt  output  1 / d_rdata  output  DW / d_rvalid  output  1  DMA grant and read return.
REQ-010 SHALL have ports: ram_sel  output  1 / ram_we  output  1 / ram_addr  output  ADDR_W / ram_wdata  output  DW / ram_rdata  input  DW  single shared program-RAM data port with 1-cycle synchronous read.

Function
REQ-011 SHALL implement a registered FSM with states IDLE, HOST, DMA; a transfer occurs in any cycle where req and gnt of one requester are both high.
REQ-012 SHALL drive h_gnt = h_req in HOST and d_gnt = d_req in DMA; both 0 in IDLE; never both 1.
REQ-013 SHALL drive ram_sel = transferring requester's req & gnt; ram_we/addr/wdata muxed from the owner combinationally; ram_we = 0 when ram_sel = 0.
REQ-014 IDLE: only h_req -> HOST; only d_req -> DMA; both -> the requester that is not last_owner; none -> IDLE; one-cycle grant latency from IDLE.
REQ-015 HOST: each transfer is one beat; after a transfer, next state d_req ? DMA : h_req ? HOST : IDLE; last_owner <= HOST.
REQ-016 HOST with h_req low (no transfer): next state d_req ? DMA : IDLE.
REQ-017 DMA: beat counter bcnt (reset 0 on DMA entry) increments on each transfer; burst ends on a transfer with d_last = 1, or with bcnt reaching MAX_BURST-1 while h_req = 1.
REQ-018 DMA burst end: last_owner <= DMA; next state h_req ? HOST : d_req ? DMA (bcnt cleared) : IDLE.
REQ-019 DMA with d_req low: h_req = 1 -> HOST (burst abandoned, last_owner <= DMA); else stay DMA, bcnt held.
REQ-020 bcnt SHALL saturate at MAX_BURST-1 when host idle; no wrap.
REQ-021 On a read transfer (we = 0), SHALL register a tag of the requester; next cycle assert that requester's rvalid for exactly one cycle with rdata = ram_rdata.
REQ-022 h_rdata/d_rdata SHALL both carry ram_rdata unconditionally; only rvalid qualifies.
REQ-023 Back-to-back reads, including owner change between them, SHALL each return rvalid to the correct requester on consecutive cycles.
REQ-024 Writes SHALL produce no rvalid.

Reset
REQ-025 rst high SHALL immediately force state IDLE, last_owner DMA (host wins first tie), bcnt 0, read tag cleared.
REQ-026 During reset: h_gnt, d_gnt, h_rvalid, d_rvalid, ram_sel, ram_we = 0; pending read returns dropped.
REQ-027 After rst deasserts, first grant no earlier than the cycle after first sampled request.

Verification
REQ-028 h_req and d_req both rise cycle 0 after reset -> h_gnt=1 cycle 1, one host beat, d_gnt=1 cycle 2.
REQ-029 DMA 4-beat write burst (d_last on beat 4), h_req idle -> ram_we=1 four consecutive cycles, addresses in order, FSM then IDLE.
REQ-030 MAX_BURST=16, DMA 40-beat burst, h_req rises at beat 5 -> DMA releases after beat 16, host gets one beat, DMA resumes with bcnt=0.
REQ-031 Host read addr 0x3 then DMA read addr 0x7 back-to-back -> h_rvalid with RAM[3] then d_rvalid with RAM[7], consecutive cycles, never both high.
REQ-032 rst asserted mid-DMA burst with a read outstanding -> all gnt/rvalid/ram_sel low same cycle; after release host wins first tie.

Source files
------------

// File: rtl/xprog_arb.sv
// Program-RAM data-port arbiter between a single-beat host and a bursting DMA engine.
// The host is never starved: it can cut a DMA burst short after MAX_BURST beats.
`ifndef PROG_RAM_ADDR_W
`define PROG_RAM_ADDR_W 10
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module xprog_arb #(
    parameter int ADDR_W    = `PROG_RAM_ADDR_W,
    parameter int DW        = `DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DW-1:0]     h_wdata,
    output logic              h_gnt,
    output logic [DW-1:0]     h_rdata,
    output logic              h_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_last,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_gnt,
    output logic [DW-1:0]     d_rdata,
    output logic              d_rvalid,
    output logic              ram_sel,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOST = 2'd1;
    localparam logic [1:0] DMA  = 2'd2;

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_BURST - 1);

    logic [1:0]    state, state_nx;
    logic          last_dma, last_dma_nx;
    logic [BW-1:0] bcnt, bcnt_nx;
    logic          burst_end;

    assign h_gnt = (state == HOST) && h_req;
    assign d_gnt = (state == DMA) && d_req;

    assign ram_sel   = h_gnt | d_gnt;
    assign ram_we    = ram_sel & (h_gnt ? h_we : d_we);
    assign ram_addr  = (state == HOST) ? h_addr : d_addr;
    assign ram_wdata = (state == HOST) ? h_wdata : d_wdata;

    assign h_rdata = ram_rdata;
    assign d_rdata = ram_rdata;

    // The host may only pre-empt a burst once the DMA has had its full MAX_BURST beats.
    assign burst_end = d_gnt && (d_last || ((bcnt == BCNT_MAX) && h_req));

    always_comb begin
        state_nx    = state;
        last_dma_nx = last_dma;
        bcnt_nx     = bcnt;
        case (state)
            IDLE: begin
                bcnt_nx = '0;
                if (h_req && d_req)
                    state_nx = last_dma ? HOST : DMA;
                else if (h_req)
                    state_nx = HOST;
                else if (d_req)
                    state_nx = DMA;
            end
            HOST: begin
                bcnt_nx = '0;
                if (h_gnt) begin
                    last_dma_nx = 1'b0;
                    state_nx    = d_req ? DMA : (h_req ? HOST : IDLE);
                end else begin
                    state_nx = d_req ? DMA : IDLE;
                end
            end
            DMA: begin
                if (burst_end) begin
                    last_dma_nx = 1'b1;
                    bcnt_nx     = '0;
                    state_nx    = h_req ? HOST : (d_req ? DMA : IDLE);
                end else if (d_gnt) begin
                    if (bcnt != BCNT_MAX)
                        bcnt_nx = bcnt + 1'b1;
                end else if (h_req) begin
                    last_dma_nx = 1'b1;
                    state_nx    = HOST;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_dma <= 1'b1;
            bcnt     <= '0;
        end else begin
            state    <= state_nx;
            last_dma <= last_dma_nx;
            bcnt     <= bcnt_nx;
        end
    end

    // Read tags line up with the RAM's one-cycle read latency; reset drops any in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            h_rvalid <= h_gnt & ~h_we;
            d_rvalid <= d_gnt & ~d_we;
        end
    end

endmodule

// File: tb/tb_xprog_arb.sv
// Scoreboard bench for xprog_arb: directed stimulus pushes expected RAM transfers and
// read returns, a negedge monitor pops and compares them as the DUT presents them.
module tb_xprog_arb;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          h_req, h_we, d_req, d_we, d_last;
    logic [AW-1:0] h_addr, d_addr, ram_addr;
    logic [DW-1:0] h_wdata, d_wdata, ram_wdata, ram_rdata, h_rdata, d_rdata;
    logic          h_gnt, h_rvalid, d_gnt, d_rvalid, ram_sel, ram_we;

    typedef struct packed {
        logic          dma;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic          dma;
        logic [DW-1:0] data;
    } rd_t;

    xfer_t exp_q[$];
    rd_t   rd_q[$];
    xfer_t mon_got, mon_exp;
    rd_t   rd_got, rd_exp;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    xprog_arb #(.ADDR_W(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .d_req(d_req), .d_we(d_we), .d_last(d_last), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .ram_sel(ram_sel), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Program RAM model: word i preloaded with 16'hA000 + i, one-cycle synchronous read.
    logic [DW-1:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'(16'hA000 + i);
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_sel) begin
                if (ram_we) mem[ram_addr] <= ram_wdata;
                else        ram_rdata     <= mem[ram_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic hr, input logic hw, input logic [AW-1:0] ha,
                                 input logic [DW-1:0] hd, input logic dr, input logic dw,
                                 input logic dl, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        d_req = dr; d_we = dw; d_last = dl; d_addr = da; d_wdata = dd;
    endtask

    task automatic idleInputs;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pushXfer(input logic dma, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        xfer_t x;
        x.dma   = dma;
        x.we    = we;
        x.addr  = a;
        x.wdata = we ? d : '0;
        exp_q.push_back(x);
    endtask

    task automatic pushRead(input logic dma, input logic [DW-1:0] d);
        rd_t r;
        r.dma  = dma;
        r.data = d;
        rd_q.push_back(r);
    endtask

    task automatic doReset;
        rst = 1'b1;
        idleInputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Streams DMA write beats and host write beats; host_at marks the cycles the host should own.
    task automatic burstRun(input int n, input int h_rise, input int last_beat,
                            input logic [63:0] host_at, input logic [AW-1:0] h_base);
        int   beat = 1;
        int   hb   = 0;
        logic eh, ed, hr, dr;
        for (int c = 0; c < n; c++) begin
            hr = (c >= h_rise);
            dr = (c < n - 1);
            eh = host_at[c];
            ed = (c >= 1) && !eh && dr;
            applyStimulus(hr, 1'b1, AW'(h_base + hb), DW'(16'hC000 + hb),
                          dr, 1'b1, (beat == last_beat), AW'(8'h40 + beat), DW'(16'hD000 + beat));
            if (eh) pushXfer(1'b0, 1'b1, AW'(h_base + hb), DW'(16'hC000 + hb));
            if (ed) pushXfer(1'b1, 1'b1, AW'(8'h40 + beat), DW'(16'hD000 + beat));
            @(negedge clk);
            checkOutput("burst_h_gnt", 32'(h_gnt), 32'(eh));
            checkOutput("burst_d_gnt", 32'(d_gnt), 32'(ed));
            tick();
            if (eh) hb++;
            if (ed) beat++;
        end
        idleInputs();
    endtask

    // Monitor: every granted RAM access and every read return must match the queue heads.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("exclusive", {29'b0, h_gnt & d_gnt, h_rvalid & d_rvalid, ram_we & ~ram_sel}, 32'd0);
            if (ram_sel) begin
                mon_got.dma   = d_gnt;
                mon_got.we    = ram_we;
                mon_got.addr  = ram_addr;
                mon_got.wdata = ram_we ? ram_wdata : '0;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_xfer", 32'(mon_got), 32'hFFFFFFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("ram_xfer", 32'(mon_got), 32'(mon_exp));
                end
            end
            if (h_rvalid || d_rvalid) begin
                rd_got.dma  = d_rvalid;
                rd_got.data = d_rvalid ? d_rdata : h_rdata;
                if (rd_q.size() == 0) begin
                    checkOutput("unexpected_rvalid", 32'(rd_got), 32'hFFFFFFFF);
                end else begin
                    rd_exp = rd_q.pop_front();
                    checkOutput("read_return", 32'(rd_got), 32'(rd_exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state while both requesters are asserting.
        applyStimulus(1'b1, 1'b1, 8'h01, 16'h0101, 1'b1, 1'b0, 1'b0, 8'h02, 16'h0202);
        @(negedge clk);
        checkOutput("rst_outputs", {26'b0, h_gnt, d_gnt, h_rvalid, d_rvalid, ram_sel, ram_we}, 32'd0);

        // Simultaneous requests out of reset: host first, one beat, then DMA.
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h10, 16'h1111, 1'b1, 1'b1, 1'b1, 8'h20, 16'h2222);
        pushXfer(1'b0, 1'b1, 8'h10, 16'h1111);
        @(negedge clk);
        checkOutput("tie_c0_gnt", {30'b0, h_gnt, d_gnt}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("tie_c1_gnt", {30'b0, h_gnt, d_gnt}, 32'd2);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 8'h20, 16'h2222);
        pushXfer(1'b1, 1'b1, 8'h20, 16'h2222);
        @(negedge clk);
        checkOutput("tie_c2_gnt", {30'b0, h_gnt, d_gnt}, 32'd1);
        tick();
        idleInputs();
        @(negedge clk);
        checkOutput("tie_c3_sel", {30'b0, d_gnt, ram_sel}, 32'd0);

        // Four-beat DMA write burst with the host idle.
        doReset();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 8'h40, 16'h4000);
        @(negedge clk);
        checkOutput("b4_c0_gnt", 32'(d_gnt), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, (i == 3), AW'(8'h40 + i), DW'(16'h4000 + i));
            pushXfer(1'b1, 1'b1, AW'(8'h40 + i), DW'(16'h4000 + i));
            @(negedge clk);
            checkOutput("b4_beat", {22'b0, d_gnt, ram_we, ram_addr}, {22'b0, 2'b11, AW'(8'h40 + i)});
            tick();
        end
        idleInputs();
        @(negedge clk);
        checkOutput("b4_after", {30'b0, d_gnt, ram_sel}, 32'd0);
        tick();
        // Host request while DMA owns the port but is quiet: one cycle to switch.
        applyStimulus(1'b1, 1'b1, 8'h50, 16'h5050, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("dma_quiet_h_gnt0", 32'(h_gnt), 32'd0);
        tick();
        pushXfer(1'b0, 1'b1, 8'h50, 16'h5050);
        @(negedge clk);
        checkOutput("dma_quiet_h_gnt1", 32'(h_gnt), 32'd1);
        tick();
        idleInputs();

        // 40-beat DMA burst, host from beat 5: host cuts in after every 16 DMA beats.
        doReset();
        burstRun(44, 5, 40, (64'd1 << 17) | (64'd1 << 34) | (64'd1 << 43), 8'h90);

        // Counter saturation: 20 unchallenged beats, then host gets in after the next beat.
        doReset();
        burstRun(23, 21, 0, 64'd1 << 22, 8'hA0);

        // Back-to-back reads with an owner change in between.
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h03, '0, 1'b1, 1'b0, 1'b1, 8'h07, '0);
        pushXfer(1'b0, 1'b0, 8'h03, '0);
        pushXfer(1'b1, 1'b0, 8'h07, '0);
        pushRead(1'b0, 16'hA003);
        pushRead(1'b1, 16'hA007);
        @(negedge clk);
        checkOutput("rd_c0_gnt", {30'b0, h_gnt, d_gnt}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("rd_c1", {29'b0, h_gnt, h_rvalid, d_rvalid}, 32'd4);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 8'h07, '0);
        @(negedge clk);
        checkOutput("rd_c2", {28'b0, d_gnt, h_rvalid, d_rvalid, 1'b0}, 32'd12);
        checkOutput("rd_c2_h_rdata", 32'(h_rdata), 32'h0000A003);
        tick();
        idleInputs();
        @(negedge clk);
        checkOutput("rd_c3", {30'b0, h_rvalid, d_rvalid}, 32'd1);
        checkOutput("rd_c3_d_rdata", 32'(d_rdata), 32'h0000A007);
        tick();
        @(negedge clk);
        checkOutput("rd_c4", {30'b0, h_rvalid, d_rvalid}, 32'd0);

        // Reset mid-burst with a DMA read still outstanding.
        doReset();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 8'h07, '0);
        pushXfer(1'b1, 1'b0, 8'h07, '0);
        @(negedge clk);
        checkOutput("mrst_c0_gnt", 32'(d_gnt), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("mrst_c1_gnt", 32'(d_gnt), 32'd1);
        tick();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h33, 16'h3333, 1'b1, 1'b0, 1'b0, 8'h07, '0);
        @(negedge clk);
        checkOutput("mrst_outputs", {26'b0, h_gnt, d_gnt, h_rvalid, d_rvalid, ram_sel, ram_we}, 32'd0);
        tick();
        rst = 1'b0;
        pushXfer(1'b0, 1'b1, 8'h33, 16'h3333);
        @(negedge clk);
        checkOutput("mrst_rel_c0", {30'b0, h_gnt, d_gnt}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("mrst_rel_c1", {30'b0, h_gnt, d_gnt}, 32'd2);
        tick();
        idleInputs();

        tick();
        tick();
        checkOutput("exp_q_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
